// File: rtl/sign_mag_accum_pkg.sv
// Shared definitions for the sign-magnitude accumulator: FSM encoding,
// saturation limit and sign/magnitude field accessors.
`ifndef SIGN_MAG_ACCUM_PKG_SV
`define SIGN_MAG_ACCUM_PKG_SV

`define SM_SIGN(v, w) v[(w)-1]
`define SM_MAG(v, w)  v[(w)-2:0]

package sign_mag_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Largest representable magnitude for a WIDTH-bit sign-magnitude word.
    function automatic int max_mag(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

`endif

// File: rtl/sign_mag_accum_if.sv
// Operand stream, run control and result bundle between an operand source
// and the sign-magnitude accumulator.
interface sign_mag_accum_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
);
    logic               start;
    logic [COUNT_W-1:0] len;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               ovf;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, busy, done, result, ovf
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, busy, done, result, ovf
    );
endinterface

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude add/sub with carry-out of the magnitude sum.
// A zero magnitude is always produced as +0, so a -0 input acts as +0.
module sm_add_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int MW = WIDTH - 1;

    logic          sign_a;
    logic          sign_b;
    logic          sign_r;
    logic [MW-1:0] mag_a;
    logic [MW-1:0] mag_b;
    logic [MW-1:0] mag_r;
    logic [MW:0]   mag_sum;

    always_comb begin
        sign_a  = `SM_SIGN(a, WIDTH);
        sign_b  = `SM_SIGN(b, WIDTH);
        mag_a   = `SM_MAG(a, WIDTH);
        mag_b   = `SM_MAG(b, WIDTH);
        mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
        carry   = 1'b0;
        sign_r  = 1'b0;
        mag_r   = '0;

        if (sign_a == sign_b) begin
            mag_r  = mag_sum[MW-1:0];
            carry  = mag_sum[MW];
            sign_r = sign_a;
        end else if (mag_a >= mag_b) begin
            mag_r  = mag_a - mag_b;
            sign_r = sign_a;
        end else begin
            mag_r  = mag_b - mag_a;
            sign_r = sign_b;
        end

        // Keep the sign on carry so the saturation mux can reuse it.
        if ((mag_r == '0) && !carry) begin
            sign_r = 1'b0;
        end

        sum = {sign_r, mag_r};
    end
endmodule

// File: rtl/sign_mag_accum.sv
// Run controller: accepts LEN sign-magnitude operands, accumulates them with
// saturation, and pulses done with a final result and sticky overflow flag.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; result/ovf hold the last run's outcome
//   ST_ACCUM | accepting operands, cnt counts remaining beats down to 1
//   ST_DONE  | one-cycle done pulse, result/ovf final
module sign_mag_accum
    import sign_mag_accum_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input logic              clk,
    input logic              reset,
    sign_mag_accum_if.slave  bus
);
    localparam logic [WIDTH-2:0]   MAX_MAG_V = (WIDTH - 1)'(max_mag(WIDTH));
    localparam logic [COUNT_W-1:0] CNT_LAST  = COUNT_W'(1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cnt_next;
    logic               ovf;
    logic               ovf_next;
    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;
    logic               in_ready;
    logic               busy;
    logic               done;

    sm_add_core #(.WIDTH(WIDTH)) u_add (
        .a     (acc),
        .b     (bus.in_data),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_next = '0;
                    ovf_next = 1'b0;
                    if (bus.len != '0) begin
                        cnt_next   = bus.len;
                        state_next = ST_ACCUM;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.in_valid) begin
                    if (add_carry) begin
                        acc_next = {add_sum[WIDTH-1], MAX_MAG_V};
                        ovf_next = 1'b1;
                    end else begin
                        acc_next = add_sum;
                    end
                    cnt_next = cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.result   = acc;
    assign bus.ovf      = ovf;
endmodule

// File: tb/tb_sign_mag_accum.sv
// Bench for sign_mag_accum: directed scenarios plus randomized runs checked
// against an integer reference model of clamped signed accumulation.
module tb_sign_mag_accum;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sign_mag_accum_if #(.WIDTH(8), .COUNT_W(4)) bus ();

    sign_mag_accum #(.WIDTH(8), .COUNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int failures  = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic int sm_to_int(input logic [7:0] v);
        return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
    endfunction

    function automatic logic [7:0] int_to_sm(input int v);
        logic [6:0] m;
        m = 7'((v < 0) ? -v : v);
        return {(v < 0), m};
    endfunction

    // Signed sum clamped to +/-127; clamping marks the run as overflowed.
    function automatic int model_step(input int acc, input logic [7:0] op, inout bit ovf);
        int s;
        s = acc + sm_to_int(op);
        if (s > 127) begin s = 127; ovf = 1'b1; end
        if (s < -127) begin s = -127; ovf = 1'b1; end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic start_run(input int l);
        bus.start = 1'b1;
        bus.len   = 4'(l);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] op, input int gap);
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = op;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        tests_run++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
        tests_run++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", bus.done); end
        tests_run++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready actual=%b required=0", bus.in_ready); end
        tests_run++; if (bus.result !== 8'h00) begin failures++; $display("FAIL reset_result actual=%h required=00", bus.result); end
        tests_run++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf actual=%b required=0", bus.ovf); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        start_run(3);
        tests_run++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready actual=%b required=1", bus.in_ready); end
        feed(8'h05, 0);
        feed(8'h07, 0);
        tests_run++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_early_done actual=%b required=0", bus.done); end
        feed(8'h83, 0);
        tests_run++; if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done actual=%b required=1", bus.done); end
        tests_run++; if (bus.result !== 8'h09) begin failures++; $display("FAIL basic_result actual=%h required=09", bus.result); end
        tests_run++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf actual=%b required=0", bus.ovf); end
        tick();
        tests_run++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL basic_idle done=%b busy=%b required=0,0", bus.done, bus.busy); end
        tests_run++; if (bus.result !== 8'h09) begin failures++; $display("FAIL basic_hold actual=%h required=09", bus.result); end
    endtask

    task automatic test_saturate();
        start_run(3);
        feed(8'h64, 0);
        feed(8'h32, 0);
        tests_run++; if (bus.result !== 8'h7F) begin failures++; $display("FAIL sat_mid_result actual=%h required=7f", bus.result); end
        tests_run++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sat_mid_ovf actual=%b required=1", bus.ovf); end
        feed(8'h94, 0);
        tests_run++; if (bus.done !== 1'b1) begin failures++; $display("FAIL sat_done actual=%b required=1", bus.done); end
        tests_run++; if (bus.result !== 8'h6B) begin failures++; $display("FAIL sat_result actual=%h required=6b", bus.result); end
        tests_run++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf actual=%b required=1", bus.ovf); end
        tick();
        tests_run++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf_sticky actual=%b required=1", bus.ovf); end
    endtask

    task automatic test_neg_zero();
        start_run(2);
        feed(8'h05, 0);
        feed(8'h85, 0);
        tests_run++; if (bus.result !== 8'h00) begin failures++; $display("FAIL negzero_cancel actual=%h required=00", bus.result); end
        tests_run++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL negzero_ovf_clear actual=%b required=0", bus.ovf); end
        tick();
        start_run(1);
        feed(8'h80, 0);
        tests_run++; if (bus.result !== 8'h00) begin failures++; $display("FAIL negzero_input actual=%h required=00", bus.result); end
        tick();
    endtask

    task automatic test_gaps();
        start_run(2);
        feed(8'h12, 0);
        bus.in_data = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            bus.start = (i == 1);
            bus.len   = 4'd5;
            tick();
            tests_run++; if (bus.result !== 8'h12 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL gap_hold result=%h in_ready=%b required=12,1", bus.result, bus.in_ready); end
        end
        bus.start = 1'b0;
        feed(8'h85, 0);
        tests_run++; if (bus.done !== 1'b1) begin failures++; $display("FAIL gap_done actual=%b required=1", bus.done); end
        tests_run++; if (bus.result !== 8'h0D) begin failures++; $display("FAIL gap_result actual=%h required=0d", bus.result); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 8'h0D) begin failures++; $display("FAIL gap_idle in_ready=%b busy=%b result=%h required=0,0,0d", bus.in_ready, bus.busy, bus.result); end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_zero_len();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h05;
        start_run(0);
        tests_run++; if (bus.done !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL zlen_done done=%b in_ready=%b required=1,0", bus.done, bus.in_ready); end
        tests_run++; if (bus.result !== 8'h00 || bus.ovf !== 1'b0) begin failures++; $display("FAIL zlen_result result=%h ovf=%b required=00,0", bus.result, bus.ovf); end
        tick();
        tests_run++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 8'h00) begin failures++; $display("FAIL zlen_after done=%b busy=%b result=%h required=0,0,00", bus.done, bus.busy, bus.result); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        start_run(3);
        feed(8'h7F, 0);
        feed(8'h05, 0);
        tests_run++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL mreset_pre_ovf actual=%b required=1", bus.ovf); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL mreset_busy busy=%b in_ready=%b required=0,0", bus.busy, bus.in_ready); end
        tests_run++; if (bus.result !== 8'h00 || bus.ovf !== 1'b0) begin failures++; $display("FAIL mreset_state result=%h ovf=%b required=00,0", bus.result, bus.ovf); end
        start_run(1);
        feed(8'h81, 0);
        tests_run++; if (bus.done !== 1'b1 || bus.result !== 8'h81) begin failures++; $display("FAIL mreset_fresh done=%b result=%h required=1,81", bus.done, bus.result); end
        tick();
    endtask

    // Back-to-back random runs: each new start arrives in the first IDLE cycle.
    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            int   l;
            int   exp_acc;
            bit   exp_ovf;
            logic [7:0] op;
            l       = $urandom_range(0, 15);
            exp_acc = 0;
            exp_ovf = 1'b0;
            start_run(l);
            for (int k = 0; k < l; k++) begin
                op = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 9) == 0) op = 8'h80;
                exp_acc = model_step(exp_acc, op, exp_ovf);
                feed(op, $urandom_range(0, 2));
                tests_run++; if (bus.result !== int_to_sm(exp_acc)) begin failures++; $display("FAIL rand_beat run=%0d beat=%0d actual=%h required=%h", r, k, bus.result, int_to_sm(exp_acc)); end
            end
            tests_run++; if (bus.done !== 1'b1) begin failures++; $display("FAIL rand_done run=%0d actual=%b required=1", r, bus.done); end
            tests_run++; if (bus.result !== int_to_sm(exp_acc) || bus.ovf !== exp_ovf) begin failures++; $display("FAIL rand_final run=%0d result=%h ovf=%b required=%h,%b", r, bus.result, bus.ovf, int_to_sm(exp_acc), exp_ovf); end
            tick();
            tests_run++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rand_idle run=%0d done=%b busy=%b required=0,0", r, bus.done, bus.busy); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_saturate();
        test_neg_zero();
        test_gaps();
        test_zero_len();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
